// File: rtl/send_sched_pkg.sv
// Shared definitions for the inter-PU SEND scheduler: FSM state encoding,
// port/index widths and the destination-port validity check.
package send_sched_pkg;

    // Width of the SEND port immediate carried by the decoder
    localparam int PORT_W = 4;

    // Width of a PU index (four PUs on the multi-PU top level)
    localparam int PU_IDX_W = 2;

    typedef enum logic [2:0] {
        SEND_IDLE  = 3'd0,
        SEND_GRANT = 3'd1,
        SEND_XFER  = 3'd2,
        SEND_DRAIN = 3'd3,
        SEND_DONE  = 3'd4
    } send_state_t;

    // A port is unusable when it names no PU or names the sender itself
    function automatic logic INVALID_PORT(input logic [PORT_W-1:0]   port,
                                          input logic [PU_IDX_W-1:0] sender,
                                          input int                  pu_num);
        return (int'(port) >= pu_num) || (port == PORT_W'(sender));
    endfunction

endpackage

// File: rtl/send_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request bit at or
// above the pointer, wrapping around. The pointer is owned by the caller.
module rr_arbiter #(
    parameter int PU_NUM = 4,
    parameter int IDX_W  = 2
) (
    input  logic [PU_NUM-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [PU_NUM-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    int               pos;
    logic [IDX_W-1:0] cand;

    // Scan from the pointer upward with wrap; the first pending request wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        cand  = '0;
        for (int k = 0; k < PU_NUM; k++) begin
            pos = int'(ptr) + k;
            if (pos >= PU_NUM) begin
                pos = pos - PU_NUM;
            end
            cand = IDX_W'(pos);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/send_sched.sv
// Inter-PU transfer scheduler. Arbitrates SEND requests round-robin and copies
// the granted block word by word from the sender's data memory into the same
// addresses of the destination PU's data memory, stalling both sides.
module send_sched
    import send_sched_pkg::*;
#(
    parameter int PU_NUM = 4,
    parameter int DW     = 16,
    parameter int AW     = 8,
    parameter int SW     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PU_NUM-1:0]        req,
    input  logic [PU_NUM*AW-1:0]     req_addr,
    input  logic [PU_NUM*SW-1:0]     req_size,
    input  logic [PU_NUM*PORT_W-1:0] req_port,
    output logic [PU_NUM-1:0]        stall,
    output logic [PU_NUM-1:0]        done,
    output logic                     err,
    output logic                     src_re,
    output logic [PU_IDX_W-1:0]      src_sel,
    output logic [AW-1:0]            src_addr,
    input  logic [DW-1:0]            src_rdata,
    output logic                     dst_we,
    output logic [PU_IDX_W-1:0]      dst_sel,
    output logic [AW-1:0]            dst_addr,
    output logic [DW-1:0]            dst_wdata
);

    localparam int IDX_W = PU_IDX_W;

    localparam logic [2:0] S_IDLE  = SEND_IDLE;
    localparam logic [2:0] S_GRANT = SEND_GRANT;
    localparam logic [2:0] S_XFER  = SEND_XFER;
    localparam logic [2:0] S_DRAIN = SEND_DRAIN;
    localparam logic [2:0] S_DONE  = SEND_DONE;

    // Control state (reset)
    logic [2:0]        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_idx;
    logic [PU_NUM-1:0] grant_oh;
    logic              err_q;
    logic [SW-1:0]     rd_cnt;
    logic              vld_p1;

    // Latched request fields and write-side address (not reset)
    logic [AW-1:0]     addr_q;
    logic [SW-1:0]     size_q;
    logic [PORT_W-1:0] port_q;
    logic [AW-1:0]     wr_addr_p1;

    // Arbiter outputs
    logic [PU_NUM-1:0] arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_found;

    // Derived helpers
    logic              port_bad;
    logic              last_rd;
    logic              busy;
    logic [AW-1:0]     rd_addr;
    logic [IDX_W-1:0]  next_ptr;
    logic [PU_NUM-1:0] dst_oh;

    rr_arbiter #(
        .PU_NUM (PU_NUM),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .found (arb_found)
    );

    assign port_bad = INVALID_PORT(port_q, grant_idx, PU_NUM);
    assign last_rd  = (rd_cnt == (size_q - SW'(1)));
    assign busy     = (state == S_GRANT) || (state == S_XFER) || (state == S_DRAIN);
    // Source address wraps in AW bits; the word counter itself never wraps
    assign rd_addr  = addr_q + AW'(rd_cnt);
    assign next_ptr = (grant_idx == IDX_W'(PU_NUM - 1)) ? '0 : grant_idx + IDX_W'(1);

    // Scheduler FSM, round-robin pointer, read counter and write-valid pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            grant_oh  <= '0;
            err_q     <= 1'b0;
            rd_cnt    <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= (state == S_XFER);
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        grant_idx <= arb_idx;
                        grant_oh  <= arb_gnt;
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    rr_ptr <= next_ptr;
                    rd_cnt <= '0;
                    if (port_bad) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else if (size_q == '0) begin
                        err_q <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    rd_cnt <= rd_cnt + SW'(1);
                    if (last_rd) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Capture the winning request's fields and delay the read address by one
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && arb_found) begin
            addr_q <= req_addr[int'(arb_idx)*AW +: AW];
            size_q <= req_size[int'(arb_idx)*SW +: SW];
            port_q <= req_port[int'(arb_idx)*PORT_W +: PORT_W];
        end
        wr_addr_p1 <= rd_addr;
    end

    // Destination stall covers GRANT through DRAIN for a valid destination
    always_comb begin
        dst_oh = '0;
        if (busy && !port_bad) begin
            dst_oh[port_q[IDX_W-1:0]] = 1'b1;
        end
    end

    // Read side: stage 0
    assign src_re   = (state == S_XFER);
    assign src_sel  = src_re ? grant_idx : '0;
    assign src_addr = src_re ? rd_addr : '0;

    // Write side: stage 1, aligned with the memory read latency
    assign dst_we    = vld_p1;
    assign dst_sel   = vld_p1 ? port_q[IDX_W-1:0] : '0;
    assign dst_addr  = vld_p1 ? wr_addr_p1 : '0;
    assign dst_wdata = vld_p1 ? src_rdata : '0;

    assign done  = (state == S_DONE) ? grant_oh : '0;
    assign err   = (state == S_DONE) && err_q;
    assign stall = (req & ~done) | dst_oh;

endmodule

// File: tb/tb_send_sched.sv
// Scoreboard bench for send_sched: stimulus pushes expected writes and done
// pulses (with their cycle numbers); a monitor pops and compares them.
module tb_send_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [31:0] req_size;
    logic [15:0] req_port;
    logic [3:0]  stall;
    logic [3:0]  done;
    logic        err;
    logic        src_re;
    logic [1:0]  src_sel;
    logic [7:0]  src_addr;
    logic [15:0] src_rdata;
    logic        dst_we;
    logic [1:0]  dst_sel;
    logic [7:0]  dst_addr;
    logic [15:0] dst_wdata;

    send_sched #(.PU_NUM(4), .DW(16), .AW(8), .SW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_port  (req_port),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .src_re    (src_re),
        .src_sel   (src_sel),
        .src_addr  (src_addr),
        .src_rdata (src_rdata),
        .dst_we    (dst_we),
        .dst_sel   (dst_sel),
        .dst_addr  (dst_addr),
        .dst_wdata (dst_wdata)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  sel;
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [3:0] oh;
        logic       err;
    } dn_t;

    wr_t  exp_wr[$];
    dn_t  exp_dn[$];
    wr_t  mw;
    dn_t  md;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t0;
    logic rearm  = 1'b0;
    int   rearm_left[4];

    // Source memory contents: word = A, 00, pu, addr
    function automatic logic [15:0] word(input logic [1:0] p, input logic [7:0] a);
        return {4'hA, 2'b00, p, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Source memory read model: data one cycle after src_re
    always @(posedge clk) begin
        if (src_re) src_rdata <= word(src_sel, src_addr);
    end

    // Monitor: pop and compare whenever the DUT writes or signals done
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dst_we) begin
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write cyc=%0d sel=%0d addr=%0h data=%0h required no write",
                                 cyc, dst_sel, dst_addr, dst_wdata);
                    end else begin
                        mw = exp_wr.pop_front();
                        check("wr_cycle", 64'(cyc), 64'(mw.cyc));
                        check("wr_sel", 64'(dst_sel), 64'(mw.sel));
                        check("wr_addr", 64'(dst_addr), 64'(mw.addr));
                        check("wr_data", 64'(dst_wdata), 64'(mw.data));
                    end
                end
                if (done != 4'd0) begin
                    if (exp_dn.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done cyc=%0d done=%0h err=%0d required none", cyc, done, err);
                    end else begin
                        md = exp_dn.pop_front();
                        check("done_cycle", 64'(cyc), 64'(md.cyc));
                        check("done_vec", 64'(done), 64'(md.oh));
                        check("done_err", 64'(err), 64'(md.err));
                    end
                end else if (err) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_err cyc=%0d actual=1 required=0", cyc);
                end
            end
        end
    end

    // Requester model: drop req after done, optionally re-raise next cycle
    initial begin : pu_model
        logic [3:0] d;
        logic [3:0] r;
        forever begin
            @(negedge clk);
            #1;
            d = done;
            if (d != 4'd0) begin
                req = req & ~d;
                r = 4'd0;
                for (int i = 0; i < 4; i++) begin
                    if (rearm && d[i] && rearm_left[i] > 0) begin
                        r[i] = 1'b1;
                        rearm_left[i]--;
                    end
                end
                if (r != 4'd0) begin
                    @(posedge clk);
                    #1;
                    req = req | r;
                end
            end
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int pu, input logic [7:0] a, input logic [7:0] s, input logic [3:0] p);
        req_addr[pu*8 +: 8] = a;
        req_size[pu*8 +: 8] = s;
        req_port[pu*4 +: 4] = p;
        req[pu] = 1'b1;
    endtask

    // Normal copy granted in IDLE at cycle t
    task automatic exp_xfer(input int pu, input logic [7:0] a, input int s, input logic [1:0] p, input int t);
        wr_t w;
        dn_t d;
        for (int k = 0; k < s; k++) begin
            w.cyc  = t + 3 + k;
            w.sel  = p;
            w.addr = a + 8'(k);
            w.data = word(2'(pu), w.addr);
            exp_wr.push_back(w);
        end
        d.cyc = t + s + 3;
        d.oh  = 4'(1 << pu);
        d.err = 1'b0;
        exp_dn.push_back(d);
    endtask

    // Rejected or empty request granted in IDLE at cycle t
    task automatic exp_short(input int pu, input logic e, input int t);
        dn_t d;
        d.cyc = t + 2;
        d.oh  = 4'(1 << pu);
        d.err = e;
        exp_dn.push_back(d);
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_dn.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_wr.size() != 0 || exp_dn.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout pending_wr=%0d pending_done=%0d required 0", exp_wr.size(), exp_dn.size());
            exp_wr.delete();
            exp_dn.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        req      = 4'd0;
        req_addr = '0;
        req_size = '0;
        req_port = '0;
        #1;
        check("reset_outputs",
              64'({stall, done, err, src_re, src_sel, src_addr, dst_we, dst_sel, dst_addr, dst_wdata}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic copy: PU0 -> PU2, 0x10..0x12, words A010/A011/A012
        go();
        set_req(0, 8'h10, 8'd3, 4'd2);
        t0 = cyc;
        exp_xfer(0, 8'h10, 3, 2'd2, t0);
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            check("stall_dst2", 64'(stall[2]), 64'((cyc >= t0 + 1) && (cyc <= t0 + 5)));
            check("stall_src0", 64'(stall[0]), 64'(cyc <= t0 + 5));
        end
        wait_quiet(50);

        // Port 5 from PU1: error done at cycle 2, no writes (rr_ptr -> 2)
        go();
        set_req(1, 8'h00, 8'd3, 4'd5);
        t0 = cyc;
        exp_short(1, 1'b1, t0);
        wait_quiet(20);

        // Contention with rr_ptr = 2: PU3 first, then PU1 (rr_ptr -> 2)
        go();
        set_req(3, 8'h40, 8'd2, 4'd0);
        set_req(1, 8'h20, 8'd1, 4'd2);
        t0 = cyc;
        exp_xfer(3, 8'h40, 2, 2'd0, t0);
        exp_xfer(1, 8'h20, 1, 2'd2, t0 + 6);
        wait_quiet(40);

        // PU2 sends to itself (error) and PU0 sends size 0; rr_ptr = 2 orders PU2 first
        go();
        set_req(2, 8'h08, 8'd4, 4'd2);
        set_req(0, 8'h08, 8'd0, 4'd1);
        t0 = cyc;
        exp_short(2, 1'b1, t0);
        exp_short(0, 1'b0, t0 + 3);
        wait_quiet(30);

        // Address wrap: 0xFE, 0xFF, 0x00, 0x01
        go();
        set_req(1, 8'hFE, 8'd4, 4'd3);
        t0 = cyc;
        exp_xfer(1, 8'hFE, 4, 2'd3, t0);
        wait_quiet(30);

        // Reset after the second write of a size-8 transfer
        go();
        set_req(2, 8'h30, 8'd8, 4'd1);
        t0 = cyc;
        for (int k = 0; k < 2; k++) begin
            mw.cyc  = t0 + 3 + k;
            mw.sel  = 2'd1;
            mw.addr = 8'h30 + 8'(k);
            mw.data = word(2'd2, mw.addr);
            exp_wr.push_back(mw);
        end
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = 4'd0;
        #1;
        check("midreset_outputs",
              64'({stall, done, err, src_re, src_sel, src_addr, dst_we, dst_sel, dst_addr, dst_wdata}), 64'd0);
        repeat (3) @(negedge clk);
        check("midreset_writes_left", 64'(exp_wr.size()), 64'd0);
        rst_n = 1'b1;
        go();
        set_req(3, 8'h50, 8'd2, 4'd0);
        t0 = cyc;
        exp_xfer(3, 8'h50, 2, 2'd0, t0);
        wait_quiet(30);

        // Fairness: all four request continuously for 16 transfers from rr_ptr = 0
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) rearm_left[i] = 3;
        @(negedge clk);
        rst_n = 1'b1;
        go();
        rearm = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 8'h60 + 8'(i), 8'd1, 4'((i + 1) % 4));
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            exp_xfer(k % 4, 8'h60 + 8'(k % 4), 1, 2'((k % 4 + 1) % 4), t0 + 5 * k);
        end
        wait_quiet(200);
        rearm = 1'b0;
        check("fair_req_idle", 64'(req), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
